// File: rtl/qdrc_bist_pkg.sv
// Shared types and constants for the QDR user-port BIST.
// FSM encoding, pattern selects and the error counter width.
package qdrc_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_WRITE    = 3'd2,
        S_READ     = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_INV   = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    localparam int ERR_CNT_WIDTH = 16;

endpackage

// File: rtl/qdrc_bist_pattern.sv
// Combinational data pattern P(addr, sel) for the BIST.
// Ports: addr/sel in, data (2*DATA_WIDTH) out.
module qdrc_bist_pattern
    import qdrc_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 21
) (
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [1:0]              sel,
    output logic [2*DATA_WIDTH-1:0] data
);

    localparam int WW = 2 * DATA_WIDTH;

    logic [WW-1:0] w;

    // Address bits repeated across the whole word.
    always_comb begin
        w = '0;
        for (int i = 0; i < WW; i++) begin
            w[i] = addr[i % ADDR_WIDTH];
        end
    end

    always_comb begin
        data = '0;
        case (sel)
            PAT_ADDR:  data = w;
            PAT_INV:   data = ~w;
            PAT_CHECK: data = addr[0] ? {DATA_WIDTH{2'b10}}
                                      : {DATA_WIDTH{2'b01}};
            PAT_SOLID: data = {WW{addr[0]}};
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/qdrc_bist.sv
// QDR user-port BIST: write pattern over 0..addr_last, read back, compare.
// Ports: strobes/addr/data/be to controller, rd data in, status out.
module qdrc_bist
    import qdrc_bist_pkg::*;
#(
    parameter int DATA_WIDTH     = 36,
    parameter int BW_WIDTH       = 4,
    parameter int ADDR_WIDTH     = 21,
    parameter int STRB_INTERVAL  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     phy_rdy,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    addr_last,
    input  logic [1:0]               pattern_sel,
    output logic                     usr_wr_strb,
    output logic                     usr_rd_strb,
    output logic [ADDR_WIDTH-1:0]    usr_addr,
    output logic [2*DATA_WIDTH-1:0]  usr_wr_data,
    output logic [2*BW_WIDTH-1:0]    usr_wr_be,
    input  logic [2*DATA_WIDTH-1:0]  usr_rd_data,
    input  logic                     usr_rd_dvld,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    first_err_addr
);

    localparam int WW    = 2 * DATA_WIDTH;
    localparam int GAP_W = (STRB_INTERVAL > 1) ? $clog2(STRB_INTERVAL) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int OUT_W = ADDR_WIDTH + 1;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] last_q;
    logic [1:0]            sel_q;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [OUT_W-1:0]      outstanding;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic                  cmp_vld;
    logic                  cmp_err;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic [WW-1:0]         wr_pat;
    logic [WW-1:0]         exp_pat;

    logic start_ok;
    logic strobing;
    logic strb_slot;
    logic at_last;
    logic out_zero;
    logic rd_dec;
    logic tmo_hit;
    logic enter_done;

    assign start_ok   = start && (state == S_IDLE);
    assign strobing   = (state == S_WRITE) || (state == S_READ);
    assign strb_slot  = strobing && (gap_cnt == '0);
    assign at_last    = (addr_cnt == last_q);
    assign out_zero   = (outstanding == '0);
    assign rd_dec     = usr_rd_dvld && !out_zero;
    assign enter_done = (state_nxt == S_DONE) && (state != S_DONE);

    // Stall detector only fires while reads are owed and none arrive.
    assign tmo_hit = ((state == S_READ) || (state == S_DRAIN))
                   && !out_zero && !usr_rd_dvld
                   && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    qdrc_bist_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_pat (
        .addr (addr_cnt),
        .sel  (sel_q),
        .data (wr_pat)
    );

    qdrc_bist_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_exp_pat (
        .addr (exp_addr),
        .sel  (sel_q),
        .data (exp_pat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (phy_rdy) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (strb_slot && at_last) state_nxt = S_READ;
            end
            S_READ: begin
                if (tmo_hit) begin
                    state_nxt = S_DONE;
                end else if (strb_slot && at_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tmo_hit || (out_zero && !cmp_vld)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        usr_wr_strb = 1'b0;
        usr_rd_strb = 1'b0;
        usr_addr    = '0;
        usr_wr_data = '0;
        usr_wr_be   = '0;
        busy        = (state != S_IDLE) && (state != S_DONE);
        case (state)
            S_WRITE: begin
                usr_wr_strb = strb_slot;
                usr_addr    = addr_cnt;
                usr_wr_data = wr_pat;
                usr_wr_be   = '1;
            end
            S_READ: begin
                usr_rd_strb = strb_slot;
                usr_addr    = addr_cnt;
            end
            default: begin
            end
        endcase
    end

    // Strobe spacing and address sequencing.
    // The spacing counter carries over from the last write into READ
    // so the first read keeps the same gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q   <= '0;
            sel_q    <= '0;
            addr_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (start_ok) begin
                last_q <= addr_last;
                sel_q  <= pattern_sel;
            end
            if (strobing) begin
                if (strb_slot) begin
                    gap_cnt  <= GAP_W'(STRB_INTERVAL - 1);
                    addr_cnt <= at_last ? '0 : addr_cnt + 1'b1;
                end else begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
            end else begin
                gap_cnt  <= '0;
                addr_cnt <= '0;
            end
        end
    end

    // Outstanding reads and stall timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
            tmo_cnt     <= '0;
        end else begin
            if (start_ok) begin
                outstanding <= '0;
            end else if (usr_rd_strb && !rd_dec) begin
                outstanding <= outstanding + 1'b1;
            end else if (!usr_rd_strb && rd_dec) begin
                outstanding <= outstanding - 1'b1;
            end

            if (start_ok || out_zero || usr_rd_dvld) begin
                tmo_cnt <= '0;
            end else if ((state == S_READ) || (state == S_DRAIN)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // One-stage compare; a dvld with nothing owed is itself an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_addr <= '0;
            cmp_vld  <= 1'b0;
            cmp_err  <= 1'b0;
            cmp_addr <= '0;
        end else if (start_ok) begin
            exp_addr <= '0;
            cmp_vld  <= 1'b0;
            cmp_err  <= 1'b0;
        end else begin
            cmp_vld <= usr_rd_dvld;
            if (usr_rd_dvld) begin
                cmp_err  <= out_zero || (usr_rd_data != exp_pat);
                cmp_addr <= exp_addr;
                exp_addr <= exp_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (start_ok) begin
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            if (cmp_vld && cmp_err) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (err_count == '0) first_err_addr <= cmp_addr;
            end
            if (tmo_hit) timeout <= 1'b1;
            if (enter_done) begin
                done <= 1'b1;
                pass <= (err_count == '0) && !tmo_hit && !timeout;
            end
        end
    end

endmodule

// File: tb/tb_qdrc_bist.sv
// Scoreboard bench for qdrc_bist with a latency-10 memory model.
// Covers clean, fault, calibration, lost read, stray dvld, reset.
module tb_qdrc_bist;

    localparam int DW  = 36;
    localparam int BW  = 4;
    localparam int AW  = 4;
    localparam int SI  = 2;
    localparam int TMO = 64;
    localparam int LAT = 10;
    localparam int WW  = 2 * DW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic          pass;
        logic          tmo;
        logic [15:0]   errs;
        logic [AW-1:0] first;
    } res_t;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
    } pend_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          phy_rdy;
    logic          start;
    logic [AW-1:0] addr_last;
    logic [1:0]    pattern_sel;
    logic          usr_wr_strb;
    logic          usr_rd_strb;
    logic [AW-1:0] usr_addr;
    logic [WW-1:0] usr_wr_data;
    logic [2*BW-1:0] usr_wr_be;
    logic [WW-1:0] usr_rd_data = '0;
    logic          usr_rd_dvld = 1'b0;
    logic          busy;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    bit flip_en = 0;
    bit drop_en = 0;
    int stray_req = 0;
    int stray_ack = 0;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    res_t          exp_res[$];
    pend_t         pend[$];
    logic [WW-1:0] mem [16];

    qdrc_bist #(
        .DATA_WIDTH     (DW),
        .BW_WIDTH       (BW),
        .ADDR_WIDTH     (AW),
        .STRB_INTERVAL  (SI),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .phy_rdy        (phy_rdy),
        .start          (start),
        .addr_last      (addr_last),
        .pattern_sel    (pattern_sel),
        .usr_wr_strb    (usr_wr_strb),
        .usr_rd_strb    (usr_rd_strb),
        .usr_addr       (usr_addr),
        .usr_wr_data    (usr_wr_data),
        .usr_wr_be      (usr_wr_be),
        .usr_rd_data    (usr_rd_data),
        .usr_rd_dvld    (usr_rd_dvld),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] pat(input int a, input int sel);
        logic [WW-1:0] w;
        logic odd;
        odd = (a & 1) != 0;
        for (int i = 0; i < WW; i++) w[i] = ((a >> (i % AW)) & 1) != 0;
        case (sel)
            0:       return w;
            1:       return ~w;
            2:       return odd ? {DW{2'b10}} : {DW{2'b01}};
            default: return {WW{odd}};
        endcase
    endfunction

    // Reference: the returned data stream, in order, against P(k).
    function automatic res_t ref_result(input int last, input int sel,
                                        input bit flip, input bit drop);
        res_t r;
        int k;
        int errs;
        logic [WW-1:0] d;
        k = 0;
        errs = 0;
        r = '0;
        for (int a = 0; a <= last; a++) begin
            if (drop && a == 7) continue;
            d = pat(a, sel);
            if (flip && a == 5) d = d ^ 72'h8;
            if (d != pat(k, sel)) begin
                if (errs == 0) r.first = AW'(k);
                errs++;
            end
            k++;
        end
        r.errs = 16'(errs);
        r.tmo  = drop && (last >= 7);
        r.pass = (errs == 0) && !r.tmo;
        return r;
    endfunction

    // Memory model, driven away from the DUT's active edge.
    always @(negedge clk) begin
        pend_t p;
        if (reset) begin
            pend.delete();
            usr_rd_dvld = 1'b0;
            usr_rd_data = '0;
        end else begin
            if (usr_wr_strb) mem[usr_addr] = usr_wr_data;
            if (usr_rd_strb && !(drop_en && usr_addr == 7)) begin
                p.due  = cyc + LAT - 1;
                p.addr = usr_addr;
                pend.push_back(p);
            end
            usr_rd_dvld = 1'b0;
            usr_rd_data = '0;
            if (stray_req != stray_ack) begin
                usr_rd_dvld = 1'b1;
                stray_ack   = stray_ack + 1;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                p = pend.pop_front();
                usr_rd_dvld = 1'b1;
                usr_rd_data = mem[p.addr];
                if (flip_en && p.addr == 5) usr_rd_data = usr_rd_data ^ 72'h8;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a strobe or done.
    logic done_prev = 1'b0;
    int   last_strb = -100;

    always @(negedge clk) begin
        wr_t  w;
        res_t r;
        if (reset) begin
            exp_wr.delete();
            exp_rd.delete();
            exp_res.delete();
        end else begin
            if (usr_wr_strb || usr_rd_strb) begin
                chk("strb_exclusive", usr_wr_strb && usr_rd_strb, 0);
                chk("strb_gap_ok", (cyc - last_strb) >= SI, 1);
                last_strb = cyc;
            end
            if (usr_wr_strb) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", usr_addr, w.addr);
                    chk("wr_data", usr_wr_data, w.data);
                    chk("wr_be", usr_wr_be, {2*BW{1'b1}});
                end
            end
            if (usr_rd_strb) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    chk("rd_addr", usr_addr, exp_rd.pop_front());
                end
            end
            if (done && !done_prev) begin
                if (exp_res.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    r = exp_res.pop_front();
                    chk("res_pass", pass, r.pass);
                    chk("res_timeout", timeout, r.tmo);
                    chk("res_err_count", err_count, r.errs);
                    if (r.errs != 0) chk("res_first_err", first_err_addr, r.first);
                    chk("res_busy_low", busy, 0);
                end
            end
        end
        done_prev = done;
    end

    task automatic start_test(input int last, input int sel, input bit accept);
        @(negedge clk);
        start       = 1'b1;
        addr_last   = AW'(last);
        pattern_sel = 2'(sel);
        if (accept) begin
            for (int a = 0; a <= last; a++) begin
                exp_wr.push_back('{addr: AW'(a), data: pat(a, sel)});
                exp_rd.push_back(AW'(a));
            end
            exp_res.push_back(ref_result(last, sel, flip_en, drop_en));
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n;
        n = 0;
        while (!(done && !busy) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, done, 1);
        @(negedge clk);
        chk({name, "_wr_left"}, exp_wr.size(), 0);
        chk({name, "_rd_left"}, exp_rd.size(), 0);
        chk({name, "_res_left"}, exp_res.size(), 0);
    endtask

    task automatic check_idle_zero(input string name);
        chk({name, "_wr_strb"}, usr_wr_strb, 0);
        chk({name, "_rd_strb"}, usr_rd_strb, 0);
        chk({name, "_be"}, usr_wr_be, 0);
        chk({name, "_addr"}, usr_addr, 0);
        chk({name, "_wdata"}, usr_wr_data, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_pass"}, pass, 0);
        chk({name, "_timeout"}, timeout, 0);
        chk({name, "_err"}, err_count, 0);
        chk({name, "_first"}, first_err_addr, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit bad;
        reset       = 1'b1;
        phy_rdy     = 1'b0;
        start       = 1'b0;
        addr_last   = '0;
        pattern_sel = '0;
        repeat (4) @(posedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        reset   = 1'b0;
        phy_rdy = 1'b1;

        // Clean run, address pattern.
        start_test(15, 0, 1);
        wait_done("clean", 1000);

        // Bit 3 flipped on the word returned for address 5.
        flip_en = 1;
        start_test(15, 1, 1);
        wait_done("fault", 1000);
        flip_en = 0;

        // Calibration hold-off.
        phy_rdy = 1'b0;
        start_test(9, 2, 1);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (usr_wr_strb || usr_rd_strb || !busy) bad = 1;
        end
        chk("cal_quiet_busy", bad, 0);
        phy_rdy = 1'b1;
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            k++;
            if (usr_wr_strb) break;
        end
        chk("cal_first_strobe", k <= 2, 1);
        wait_done("cal", 1000);

        // Response for address 7 never returns.
        drop_en = 1;
        start_test(15, 3, 1);
        wait_done("lost", 2000);
        chk("lost_timeout", timeout, 1);
        chk("lost_pass", pass, 0);
        chk("lost_busy", busy, 0);
        drop_en = 0;

        // Full all-ones address range, then a stray dvld.
        start_test(15, 2, 1);
        wait_done("bound", 1000);
        stray_req = stray_req + 1;
        repeat (4) @(negedge clk);
        chk("stray_err", err_count, 1);

        // Second start while busy is ignored; new start clears errors.
        start_test(15, 0, 1);
        chk("restart_err_clr", err_count, 0);
        chk("restart_done_clr", done, 0);
        repeat (20) @(negedge clk);
        start_test(3, 2, 0);
        wait_done("ignored", 1000);

        // Reset in the middle of READ.
        start_test(15, 1, 1);
        k = 0;
        while (!usr_rd_strb && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("reached_read", usr_rd_strb, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle_zero("midreset");
        @(negedge clk);
        reset = 1'b0;

        // Recovery after reset.
        start_test(3, 3, 1);
        wait_done("recover", 1000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
